// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
//
// Bundles the host byte-stream handshake and the memory write port driven by
// the program loader.
//
// Signals:
//   in_valid   host presents a byte on in_data
//   in_data    stream byte (DATA_W)
//   in_ready   loader can accept a byte this cycle
//   mem_addr   memory write address (ADDR_W)
//   mem_data   memory write data (DATA_W)
//   mem_write  one-cycle memory write strobe
//
// Modports:
//   master  the loader side (drives in_ready and the memory port)
//   slave   the environment side (host stream source plus memory sink)
// ----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_write;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_addr,
        output mem_data,
        output mem_write
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_write
    );
endinterface

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//
// Loads a framed byte stream from a host into memory and holds the CPU in
// reset until a complete image is present. Frame: ADDR, LEN, LEN data bytes,
// then an optional CSUM byte (8-bit modular sum of the data bytes).
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, the frame carries a CSUM byte and a
//                       mismatch parks the loader in S_ERR with err = 1.
//                       When undefined, the frame ends after the last data
//                       byte and err is tied 0.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        program_loader_if.master: stream in_valid/in_data/in_ready
//              and memory mem_addr/mem_data/mem_write
//   load_req   one-cycle pulse; restarts loading from S_DONE or S_ERR
//   cpu_rst    holds the control and processing units in reset
//   done       image loaded (and verified when checksumming is built in)
//   err        checksum mismatch
// ----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.master bus,
    input  logic             load_req,
    output logic             cpu_rst,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the data phase is exhausted.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] sum, sum_n;
    logic              wr_n;
    logic [ADDR_W-1:0] wa_n;
    logic [DATA_W-1:0] wd_n;
    logic              accept;

    // in_ready is the only combinational output: a pure state decode.
    assign bus.in_ready = (state == S_ADDR) || (state == S_LEN) ||
                          (state == S_DATA) || (state == S_CSUM);
    assign accept       = bus.in_valid && bus.in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ADDR;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sum_n   = sum;
        wr_n    = 1'b0;
        wa_n    = bus.mem_addr;
        wd_n    = bus.mem_data;

        case (state)
            S_ADDR: begin
                if (accept) begin
                    ptr_n   = ADDR_W'(bus.in_data);
                    state_n = S_LEN;
                end
            end

            S_LEN: begin
                if (accept) begin
                    cnt_n = ADDR_W'(bus.in_data);
                    sum_n = '0;
                    if (bus.in_data == '0) begin
                        state_n = S_TAIL;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    wr_n  = 1'b1;
                    wa_n  = ptr;
                    wd_n  = bus.in_data;
                    ptr_n = ptr + ADDR_W'(1);
                    sum_n = sum + bus.in_data;
                    cnt_n = cnt - ADDR_W'(1);
                    // cnt still holds the pre-decrement value here.
                    if (cnt == ADDR_W'(1)) begin
                        state_n = S_TAIL;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (bus.in_data == sum) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
`endif

            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_n = S_ADDR;
                end
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. Status flags are registered from
    // the next state so they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            cnt           <= '0;
            sum           <= '0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.mem_write <= 1'b0;
            cpu_rst       <= 1'b1;
            done          <= 1'b0;
        end else begin
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            sum           <= sum_n;
            bus.mem_addr  <= wa_n;
            bus.mem_data  <= wd_n;
            bus.mem_write <= wr_n;
            cpu_rst       <= (state_n != S_DONE);
            done          <= (state_n == S_DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= (state_n == S_ERR);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
